// File: rtl/axi_ctrl_pkg.sv
// Shared types for the AXI transaction scheduler: FSM states, run status codes,
// and a width helper for the cycle counters sized from their terminal count.
package axi_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        GAP   = 3'd3,
        DONE  = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        ST_OK  = 2'd0,
        ST_ERR = 2'd1,
        ST_TMO = 2'd2,
        ST_ABT = 2'd3
    } status_e;

    // Bits needed for a counter that runs 0 .. n-1 (never narrower than 1).
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Purpose: W-bit event counter, synchronous clear, increment that sticks at all-ones.
// Latency: count reflects a clr/inc one cycle after it is asserted.
// Backpressure: none; clr has priority over inc.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear wins, otherwise increment unless already saturated.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/axi_txn_scheduler.sv
// Purpose: drives the master engine through a programmed run of transactions with timeout, retry, gap and abort.
// Latency: init pulse one cycle after an accepted start; done pulse one cycle after the final completion/timeout/abort.
// Backpressure: none; start is ignored while busy and only one master transaction is ever outstanding.
module axi_txn_scheduler
    import axi_ctrl_pkg::*;
#(
    parameter int CNT_W          = 16,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int MAX_RETRY      = 3,
    parameter int GAP_CYCLES     = 8
) (
    input  logic             i_sysclk,
    input  logic             i_sysrstn,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [CNT_W-1:0] i_txn_count,
    input  logic             i_continue_on_error,
    output logic             o_init_axi_txn,
    input  logic             i_txn_done,
    input  logic             i_error,
    output logic             o_busy,
    output logic             o_done,
    output logic [1:0]       o_status,
    output logic [CNT_W-1:0] o_txn_ok,
    output logic [CNT_W-1:0] o_err_count,
    output logic [CNT_W-1:0] o_retry_count
);

    localparam int TMO_W = cnt_width(TIMEOUT_CYCLES);
    localparam int GAP_W = cnt_width(GAP_CYCLES);
    localparam int RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

    // With no gap configured, a finished transaction goes straight to the next issue.
    localparam state_e AFTER_TXN = (GAP_CYCLES == 0) ? ISSUE : GAP;

    state_e           state_q,  state_d;
    status_e          status_q, status_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic [CNT_W-1:0] idx_q,    idx_d;
    logic             cont_q,   cont_d;
    logic [RTY_W-1:0] rty_q,    rty_d;
    logic [TMO_W-1:0] tmo_q,    tmo_d;
    logic [GAP_W-1:0] gap_q,    gap_d;
    logic             done_prev_q;

    logic start_acc;
    logic done_edge;
    logic last_txn;
    logic ok_inc;
    logic err_inc;
    logic rty_inc;

    assign done_edge = i_txn_done & ~done_prev_q;
    // idx never exceeds count-1, so idx+1 cannot wrap even for an all-ones count.
    assign last_txn  = ((idx_q + CNT_W'(1)) == count_q);

    // Next-state, run bookkeeping and counter-increment strobes.
    always_comb begin
        state_d   = state_q;
        status_d  = status_q;
        count_d   = count_q;
        idx_d     = idx_q;
        cont_d    = cont_q;
        rty_d     = rty_q;
        tmo_d     = (state_q == WAIT) ? tmo_q + 1'b1 : '0;
        gap_d     = (state_q == GAP)  ? gap_q + 1'b1 : '0;
        start_acc = 1'b0;
        ok_inc    = 1'b0;
        err_inc   = 1'b0;
        rty_inc   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (i_start) begin
                    start_acc = 1'b1;
                    count_d   = i_txn_count;
                    cont_d    = i_continue_on_error;
                    status_d  = ST_OK;
                    idx_d     = '0;
                    rty_d     = '0;
                    state_d   = (i_txn_count == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                if (i_abort) begin
                    status_d = ST_ABT;
                    state_d  = DONE;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // Abort beats a completion, and a completion beats the timeout.
                if (i_abort) begin
                    status_d = ST_ABT;
                    state_d  = DONE;
                end else if (done_edge && !i_error) begin
                    ok_inc  = 1'b1;
                    rty_d   = '0;
                    idx_d   = idx_q + CNT_W'(1);
                    state_d = last_txn ? DONE : AFTER_TXN;
                end else if (done_edge) begin
                    err_inc = 1'b1;
                    if (rty_q < RTY_MAX) begin
                        rty_inc = 1'b1;
                        rty_d   = rty_q + 1'b1;
                        state_d = AFTER_TXN;
                    end else if (cont_q) begin
                        // Retries exhausted: give up on this one but keep the run going.
                        status_d = ST_ERR;
                        rty_d    = '0;
                        idx_d    = idx_q + CNT_W'(1);
                        state_d  = last_txn ? DONE : AFTER_TXN;
                    end else begin
                        status_d = ST_ERR;
                        state_d  = DONE;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    status_d = ST_TMO;
                    state_d  = DONE;
                end
            end
            GAP: begin
                if (i_abort) begin
                    status_d = ST_ABT;
                    state_d  = DONE;
                end else if (gap_q == GAP_LAST) begin
                    state_d = ISSUE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM and run-context registers.
    always_ff @(posedge i_sysclk or negedge i_sysrstn) begin
        if (!i_sysrstn) begin
            state_q     <= IDLE;
            status_q    <= ST_OK;
            count_q     <= '0;
            idx_q       <= '0;
            cont_q      <= 1'b0;
            rty_q       <= '0;
            tmo_q       <= '0;
            gap_q       <= '0;
            done_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            status_q    <= status_d;
            count_q     <= count_d;
            idx_q       <= idx_d;
            cont_q      <= cont_d;
            rty_q       <= rty_d;
            tmo_q       <= tmo_d;
            gap_q       <= gap_d;
            done_prev_q <= i_txn_done;
        end
    end

    sat_counter #(.W(CNT_W)) u_txn_ok (
        .clk   (i_sysclk),
        .rst_n (i_sysrstn),
        .clr   (start_acc),
        .inc   (ok_inc),
        .cnt   (o_txn_ok)
    );

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk   (i_sysclk),
        .rst_n (i_sysrstn),
        .clr   (start_acc),
        .inc   (err_inc),
        .cnt   (o_err_count)
    );

    sat_counter #(.W(CNT_W)) u_retry_cnt (
        .clk   (i_sysclk),
        .rst_n (i_sysrstn),
        .clr   (start_acc),
        .inc   (rty_inc),
        .cnt   (o_retry_count)
    );

    assign o_init_axi_txn = (state_q == ISSUE);
    assign o_done         = (state_q == DONE);
    assign o_busy         = (state_q != IDLE);
    assign o_status       = status_q;

endmodule

// File: tb/tb_axi_txn_scheduler.sv
`timescale 1ns/1ps
// Scheduler bench: instance A (16-bit, timeout 64, gap 8), instance B (4-bit, timeout 16, no gap).
// A behavioural master answers each init after a programmed delay with a programmed error pattern.
// Expected run results are queued at start and compared when the DUT pulses o_done.
module tb_axi_txn_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic        a_start, a_abort, a_cont, a_done, a_err;
    logic [15:0] a_count;
    logic        a_init, a_busy, a_odone;
    logic [1:0]  a_status;
    logic [15:0] a_ok, a_errc, a_rty;

    logic        b_start, b_abort, b_cont, b_done, b_err;
    logic [3:0]  b_count;
    logic        b_init, b_busy, b_odone;
    logic [1:0]  b_status;
    logic [3:0]  b_ok, b_errc, b_rty;

    axi_txn_scheduler #(.CNT_W(16), .TIMEOUT_CYCLES(64), .MAX_RETRY(3), .GAP_CYCLES(8)) dut_a (
        .i_sysclk(clk), .i_sysrstn(rst_n), .i_start(a_start), .i_abort(a_abort),
        .i_txn_count(a_count), .i_continue_on_error(a_cont), .o_init_axi_txn(a_init),
        .i_txn_done(a_done), .i_error(a_err), .o_busy(a_busy), .o_done(a_odone),
        .o_status(a_status), .o_txn_ok(a_ok), .o_err_count(a_errc), .o_retry_count(a_rty)
    );

    axi_txn_scheduler #(.CNT_W(4), .TIMEOUT_CYCLES(16), .MAX_RETRY(3), .GAP_CYCLES(0)) dut_b (
        .i_sysclk(clk), .i_sysrstn(rst_n), .i_start(b_start), .i_abort(b_abort),
        .i_txn_count(b_count), .i_continue_on_error(b_cont), .o_init_axi_txn(b_init),
        .i_txn_done(b_done), .i_error(b_err), .o_busy(b_busy), .o_done(b_odone),
        .o_status(b_status), .o_txn_ok(b_ok), .o_err_count(b_errc), .o_retry_count(b_rty)
    );

    typedef struct {
        int          id;
        int          inst;
        int          count;
        bit          cont;
        int          delay;     // master response delay after init; 0 = never responds
        logic [63:0] errs;      // bit r = error flag on the r-th response
        int          abort_at;  // response index that also raises abort; -1 = never
        int          inits;
        int          status;
        int          ok;
        int          errc;
        int          rty;
        int          spacing;   // expected init-to-init distance; 0 = not checked
        int          dl;        // expected last-init-to-done distance; -1 = not checked
        int          restart;   // cycle offset of a second start pulse; 0 = none
    } vec_t;

    vec_t tbl[14];
    vec_t sb[$];

    int n_pass = 0;
    int n_chk  = 0;
    int cyc    = 0;

    int          m_delay[2];
    logic [63:0] m_errs[2];
    int          m_abort_at[2];
    int          m_resp[2];

    int init_cnt[2];
    int done_cnt[2];
    int first_init[2];
    int last_init[2];
    int done_cyc[2];
    int exp_sp;
    int sp_bad;
    int sp_seen;

    task automatic check(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    function automatic int g_init(input int k);  return (k == 0) ? int'(a_init)   : int'(b_init);   endfunction
    function automatic int g_done(input int k);  return (k == 0) ? int'(a_odone)  : int'(b_odone);  endfunction
    function automatic int g_busy(input int k);  return (k == 0) ? int'(a_busy)   : int'(b_busy);   endfunction
    function automatic int g_stat(input int k);  return (k == 0) ? int'(a_status) : int'(b_status); endfunction
    function automatic int g_ok(input int k);    return (k == 0) ? int'(a_ok)     : int'(b_ok);     endfunction
    function automatic int g_errc(input int k);  return (k == 0) ? int'(a_errc)   : int'(b_errc);   endfunction
    function automatic int g_rty(input int k);   return (k == 0) ? int'(a_rty)    : int'(b_rty);    endfunction

    task automatic drive_resp(input int k, input logic d, input logic e, input logic ab);
        if (k == 0) begin a_done = d; a_err = e; a_abort = ab; end
        else        begin b_done = d; b_err = e; end
    endtask

    task automatic set_start(input int k, input logic s, input int cnt, input logic c);
        if (k == 0) begin a_start = s; a_count = 16'(cnt); a_cont = c; end
        else        begin b_start = s; b_count = 4'(cnt);  b_cont = c; end
    endtask

    task automatic ticker();
        forever begin
            @(posedge clk);
            cyc++;
        end
    endtask

    // Master model: one outstanding transaction, done/error held for one cycle.
    task automatic master(input int k);
        int d;
        int r;
        forever begin
            @(negedge clk);
            if (g_init(k) == 1 && m_delay[k] > 0) begin
                d = m_delay[k];
                r = m_resp[k];
                m_resp[k] = r + 1;
                repeat (d) @(posedge clk);
                #1;
                drive_resp(k, 1'b1, m_errs[k][r], m_abort_at[k] == r);
                @(posedge clk);
                #1;
                drive_resp(k, 1'b0, 1'b0, 1'b0);
            end
        end
    endtask

    // Observes init/done pulses and scores each finished run against the queued expectation.
    task automatic monitor();
        vec_t e;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (g_init(k) == 1) begin
                    if (init_cnt[k] == 0) first_init[k] = cyc;
                    else if (exp_sp > 0 && (cyc - last_init[k]) != exp_sp) begin
                        sp_bad++;
                        sp_seen = cyc - last_init[k];
                    end
                    init_cnt[k]++;
                    last_init[k] = cyc;
                end
                if (g_done(k) == 1) begin
                    done_cnt[k]++;
                    done_cyc[k] = cyc;
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        check($sformatf("t%0d_inst", e.id),   k,           e.inst);
                        check($sformatf("t%0d_status", e.id), g_stat(k),   e.status);
                        check($sformatf("t%0d_txn_ok", e.id), g_ok(k),     e.ok);
                        check($sformatf("t%0d_err_cnt", e.id), g_errc(k),  e.errc);
                        check($sformatf("t%0d_rty_cnt", e.id), g_rty(k),   e.rty);
                        check($sformatf("t%0d_inits", e.id),  init_cnt[k], e.inits);
                        if (e.spacing > 0)
                            check($sformatf("t%0d_spacing", e.id), (sp_bad == 0) ? exp_sp : sp_seen, e.spacing);
                        if (e.dl > 0)
                            check($sformatf("t%0d_done_after_init", e.id), cyc - last_init[k], e.dl);
                    end
                end
            end
        end
    endtask

    task automatic run(input vec_t v);
        int k;
        int t;
        int start_cyc;
        k = v.inst;
        @(posedge clk);
        #1;
        m_delay[k]    = v.delay;
        m_errs[k]     = v.errs;
        m_abort_at[k] = v.abort_at;
        m_resp[k]     = 0;
        init_cnt[k]   = 0;
        done_cnt[k]   = 0;
        exp_sp        = v.spacing;
        sp_bad        = 0;
        sp_seen       = 0;
        sb.push_back(v);
        set_start(k, 1'b1, v.count, v.cont);
        start_cyc = cyc;
        t = 0;
        do begin
            @(posedge clk);
            #1;
            t++;
            if (t == 1) check($sformatf("t%0d_busy_after_start", v.id), g_busy(k), 1);
            if (v.restart > 0 && (cyc - start_cyc) == v.restart) set_start(k, 1'b1, 9, 1'b0);
            else set_start(k, 1'b0, v.count, v.cont);
        end while (done_cnt[k] == 0 && t < 3000);
        set_start(k, 1'b0, v.count, v.cont);
        repeat (40) @(posedge clk);
        @(negedge clk);
        check($sformatf("t%0d_done_once", v.id),    done_cnt[k], 1);
        check($sformatf("t%0d_no_late_init", v.id), init_cnt[k], v.inits);
        check($sformatf("t%0d_busy_idle", v.id),    g_busy(k),   0);
        check($sformatf("t%0d_status_hold", v.id),  g_stat(k),   v.status);
        if (v.inits > 0)
            check($sformatf("t%0d_init_latency", v.id), first_init[k] - start_cyc, 1);
        else
            check($sformatf("t%0d_done_within_2", v.id),
                  int'((done_cyc[k] - start_cyc) >= 1 && (done_cyc[k] - start_cyc) <= 2), 1);
        if (sb.size() > 0) sb.delete();
    endtask

    initial begin
        int s0;
        rst_n = 1'b1;
        set_start(0, 1'b0, 0, 1'b0);
        set_start(1, 1'b0, 0, 1'b0);
        drive_resp(0, 1'b0, 1'b0, 1'b0);
        drive_resp(1, 1'b0, 1'b0, 1'b0);
        b_abort = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_delay[k] = 0; m_errs[k] = '0; m_abort_at[k] = -1; m_resp[k] = 0;
            init_cnt[k] = 0; done_cnt[k] = 0; first_init[k] = 0; last_init[k] = 0; done_cyc[k] = 0;
        end
        exp_sp = 0; sp_bad = 0; sp_seen = 0;

        //         id inst cnt cont dly errs                   abrt inits st ok errc rty sp  dl rst
        tbl[0]  = '{0,  0,  4, 1'b0, 20, 64'h0,                 -1,  4,  0, 4,  0,  0, 29, 21,  0};
        tbl[1]  = '{1,  0,  2, 1'b0, 20, 64'h6,                 -1,  4,  0, 2,  2,  2, 29, 21,  0};
        tbl[2]  = '{2,  0,  3, 1'b0, 20, 64'hF,                 -1,  4,  1, 0,  4,  3, 29, 21,  0};
        tbl[3]  = '{3,  0,  3, 1'b1, 20, 64'hF,                 -1,  6,  1, 2,  4,  3, 29, 21,  0};
        tbl[4]  = '{4,  0,  5, 1'b0, 20, 64'h0,                  1,  2,  3, 1,  0,  0, 29, 21,  0};
        tbl[5]  = '{5,  0,  3, 1'b0,  5, 64'h0,                 -1,  3,  0, 3,  0,  0, 14,  6,  0};
        tbl[6]  = '{6,  0,  0, 1'b0, 20, 64'h0,                 -1,  0,  0, 0,  0,  0,  0, -1,  0};
        tbl[7]  = '{7,  0,  2, 1'b0, 20, 64'h0,                 -1,  2,  0, 2,  0,  0, 29, 21, 10};
        tbl[8]  = '{8,  0,  2, 1'b0, 20, 64'h0,                 -1,  2,  0, 2,  0,  0, 29, 21, 51};
        tbl[9]  = '{9,  1,  1, 1'b0,  0, 64'h0,                 -1,  1,  2, 0,  0,  0,  0, 17,  0};
        tbl[10] = '{10, 1,  1, 1'b0, 16, 64'h0,                 -1,  1,  0, 1,  0,  0,  0, 17,  0};
        tbl[11] = '{11, 1,  1, 1'b0, 17, 64'h0,                 -1,  1,  2, 0,  0,  0,  0, 17,  0};
        tbl[12] = '{12, 1, 15, 1'b0,  3, 64'h0,                 -1, 15,  0, 15, 0,  0,  4,  4,  0};
        tbl[13] = '{13, 1, 15, 1'b1,  3, 64'hFFFF_FFFF_FFFF_FFFF, -1, 60, 1, 0, 15, 15,  4,  4,  0};

        fork
            ticker();
            monitor();
            master(0);
            master(1);
        join_none

        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_init",   int'(a_init),   0);
        check("rst_busy",   int'(a_busy),   0);
        check("rst_done",   int'(a_odone),  0);
        check("rst_status", int'(a_status), 0);
        check("rst_ok",     int'(a_ok),     0);
        check("rst_errc",   int'(a_errc),   0);
        check("rst_rty",    int'(a_rty),    0);
        check("rst_b_busy", int'(b_busy),   0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 14; i++) run(tbl[i]);

        // Reset in the middle of the third transaction's WAIT.
        @(posedge clk);
        #1;
        m_delay[0] = 20; m_errs[0] = '0; m_abort_at[0] = -1; m_resp[0] = 0;
        set_start(0, 1'b1, 4, 1'b0);
        s0 = cyc;
        @(posedge clk);
        #1 set_start(0, 1'b0, 4, 1'b0);
        while ((cyc - s0) < 62) @(posedge clk);
        #1;
        check("mid_run_busy", int'(a_busy), 1);
        check("mid_run_ok",   int'(a_ok),   2);
        #1 rst_n = 1'b0;
        #1;
        check("arst_init",   int'(a_init),   0);
        check("arst_busy",   int'(a_busy),   0);
        check("arst_done",   int'(a_odone),  0);
        check("arst_status", int'(a_status), 0);
        check("arst_ok",     int'(a_ok),     0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        init_cnt[0] = 0;
        repeat (30) @(posedge clk);
        @(negedge clk);
        check("no_init_after_release", init_cnt[0], 0);
        check("idle_after_release",    int'(a_busy), 0);

        run(tbl[0]);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
